// File: rtl/mem_pkg.sv
// Shared types for the store path: store size encoding, FIFO entry layout and lane masks.
package mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_BE_W   = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } store_size_t;

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_SPLIT = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
        store_size_t           size;
        logic                  split;
    } store_entry_t;

    function automatic logic [MEM_BE_W-1:0] size_mask(input store_size_t size);
        logic [MEM_BE_W-1:0] mask;
        case (size)
            SIZE_B:  mask = 4'b0001;
            SIZE_H:  mask = 4'b0011;
            SIZE_W:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_write_if.sv
// Data-memory write port: the store controller drives mem_out, the memory samples mem_in.
interface mem_write #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WR_EN_WIDTH = 4
);
    logic [WR_EN_WIDTH-1:0] wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;

    modport mem_out (output wr_en, output wr_addr, output wr_data);
    modport mem_in  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/store_fifo.sv
// Small synchronous FIFO for store entries; pointers wrap modulo DEPTH (power of two).
module store_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    T               mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic           do_push_s, do_pop_s;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == {(PW+1){1'b0}});
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW+1){1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/store_write_ctrl.sv
// Store write controller: buffers MEM-stage stores and drains one lane-aligned write per cycle.
// Macro STORE_SPLIT_EN: misaligned SH/SW become two writes instead of being dropped.
module store_write_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = MEM_DATA_W,
    parameter int ADDR_WIDTH  = MEM_ADDR_W,
    parameter int WR_EN_WIDTH = MEM_BE_W,
    parameter int DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [1:0]            req_size,
    input  logic                  mem_busy,
    output logic                  misalign,
    output logic                  idle,
    mem_write.mem_out             wr
);
    localparam int CW = $clog2(DEPTH) + 1;

    store_entry_t             push_entry_s, head_s;
    logic                     accept_s, illegal_s, unaligned_s;
    logic                     push_s, pop_s, full_s, empty_s;
    logic [CW-1:0]            count_s;
    wr_state_t                state_q, state_d;
    logic [WR_EN_WIDTH-1:0]   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d, word_addr_s;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d, repl_data_s, rot_data_s;
    logic [2*DATA_WIDTH-1:0]  rot_wide_s;
    logic [2*WR_EN_WIDTH-1:0] lanes_s;
    logic                     misalign_q, misalign_d;

    assign req_ready   = !full_s;
    assign accept_s    = req_valid && req_ready;
    assign illegal_s   = (req_size == 2'b11);
    assign unaligned_s = ((req_size == 2'b01) && req_addr[0]) ||
                         ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        push_entry_s.addr = req_addr;
        push_entry_s.data = req_data;
        push_entry_s.size = store_size_t'(req_size);
`ifdef STORE_SPLIT_EN
        push_entry_s.split = unaligned_s;
        push_s             = accept_s && !illegal_s;
        misalign_d         = accept_s && illegal_s;
`else
        push_entry_s.split = 1'b0;
        push_s             = accept_s && !illegal_s && !unaligned_s;
        misalign_d         = accept_s && (illegal_s || unaligned_s);
`endif
    end

    store_fifo #(
        .DEPTH (DEPTH),
        .T     (store_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_entry_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Low half of lanes_s is the addressed word, high half spills into the next word.
    assign lanes_s     = {{WR_EN_WIDTH{1'b0}}, size_mask(head_s.size)} << head_s.addr[1:0];
    assign word_addr_s = {head_s.addr[ADDR_WIDTH-1:2], 2'b00};
    assign rot_wide_s  = {head_s.data, head_s.data} << {head_s.addr[1:0], 3'b000};
    assign rot_data_s  = rot_wide_s[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        case (head_s.size)
            SIZE_B:  repl_data_s = {4{head_s.data[7:0]}};
            SIZE_H:  repl_data_s = {2{head_s.data[15:0]}};
            default: repl_data_s = head_s.data;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pop_s     = 1'b0;
        wr_en_d   = {WR_EN_WIDTH{1'b0}};
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_ISSUE: begin
                if (!empty_s && !mem_busy) begin
                    wr_en_d   = lanes_s[WR_EN_WIDTH-1:0];
                    wr_addr_d = word_addr_s;
                    if (head_s.split) begin
                        wr_data_d = rot_data_s;
                    end else begin
                        wr_data_d = repl_data_s;
                    end
                    // A misaligned half-word inside one word still needs only one write.
                    if (head_s.split && (lanes_s[2*WR_EN_WIDTH-1:WR_EN_WIDTH] != {WR_EN_WIDTH{1'b0}})) begin
                        state_d = ST_SPLIT;
                    end else begin
                        pop_s = 1'b1;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_SPLIT: begin
                if (!mem_busy) begin
                    wr_en_d   = lanes_s[2*WR_EN_WIDTH-1:WR_EN_WIDTH];
                    wr_addr_d = word_addr_s + ADDR_WIDTH'(4);
                    wr_data_d = rot_data_s;
                    pop_s     = 1'b1;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_SPLIT;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ISSUE;
            wr_en_q    <= {WR_EN_WIDTH{1'b0}};
            wr_addr_q  <= {ADDR_WIDTH{1'b0}};
            wr_data_q  <= {DATA_WIDTH{1'b0}};
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign misalign   = misalign_q;
    assign idle       = (count_s == {CW{1'b0}}) && (state_q == ST_ISSUE);
    assign wr.wr_en   = wr_en_q;
    assign wr.wr_addr = wr_addr_q;
    assign wr.wr_data = wr_data_q;

endmodule

// File: tb/tb_store_write_ctrl.sv
// Bench for store_write_ctrl: directed scenarios plus random traffic against a byte-level store model.
module tb_store_write_ctrl;
    localparam int DEPTH = 4;
`ifdef STORE_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        mem_busy = 1'b0;
    logic        misalign;
    logic        idle;

    mem_write #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WR_EN_WIDTH(4)) wr_if ();

    store_write_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .WR_EN_WIDTH(4), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_busy(mem_busy), .misalign(misalign), .idle(idle), .wr(wr_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] addr;
        logic [31:0] data;
        bit          full_cmp;
        bit          last;
        int          acc_cyc;
    } exp_wr_t;

    exp_wr_t     exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pending = 0;
    int          cyc = 0;

    // Expected writes from the byte-level meaning of a store: byte i of the data lands at address a+i.
    function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] sz, input int c);
        exp_wr_t     w0, w1;
        logic [31:0] ba;
        int          nbytes;
        bit          unal;
        nbytes      = 1 << sz;
        unal        = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        w0.en       = 4'b0;
        w0.addr     = a & 32'hFFFF_FFFC;
        w0.data     = 32'h0;
        w0.full_cmp = !unal;
        w0.acc_cyc  = c;
        w0.last     = 1'b1;
        w1          = w0;
        w1.addr     = w0.addr + 32'd4;
        for (int i = 0; i < nbytes; i++) begin
            ba = a + 32'(i);
            if ((ba & 32'hFFFF_FFFC) == w0.addr) begin
                w0.en[ba[1:0]]          = 1'b1;
                w0.data[8*ba[1:0] +: 8] = d[8*i +: 8];
            end else begin
                w1.en[ba[1:0]]          = 1'b1;
                w1.data[8*ba[1:0] +: 8] = d[8*i +: 8];
            end
        end
        if (!unal) begin
            case (sz)
                2'd0:    w0.data = {4{d[7:0]}};
                2'd1:    w0.data = {2{d[15:0]}};
                default: w0.data = d;
            endcase
        end
        w0.last = (w1.en == 4'b0);
        exp_q.push_back(w0);
        if (w1.en != 4'b0) exp_q.push_back(w1);
    endfunction

    // Monitor state: what was presented before the last clock edge.
    bit          rst_prev = 1'b1;
    bit          busy_prev = 1'b0;
    bit          acc_p = 1'b0;
    bit          exp_mis;
    bit          unal_p;
    logic [31:0] a_p, d_p, last_addr = 32'h0, last_data = 32'h0, m;
    logic [1:0]  s_p;
    exp_wr_t     w;

    always @(negedge clk) begin
        cyc++;
        if (rst_prev) begin
            exp_q.delete();
            pending = 0;
            checks++;
            if (wr_if.wr_en !== 4'b0 || misalign !== 1'b0 || req_ready !== 1'b1 || idle !== 1'b1)
                begin errors++; $display("FAIL mon_reset cyc=%0d en=%b mis=%b rdy=%b idle=%b required 0000/0/1/1", cyc, wr_if.wr_en, misalign, req_ready, idle); end
        end else begin
            exp_mis = 1'b0;
            if (acc_p) begin
                unal_p = (s_p == 2'd1 && a_p[0]) || (s_p == 2'd2 && a_p[1:0] != 2'd0);
                if (s_p != 2'b11 && (!unal_p || SPLIT_EN)) begin
                    model_store(a_p, d_p, s_p, cyc - 1);
                    pending++;
                end else begin
                    exp_mis = 1'b1;
                end
            end
            checks++;
            if (misalign !== exp_mis)
                begin errors++; $display("FAIL mon_misalign cyc=%0d got=%b required=%b", cyc, misalign, exp_mis); end
            if (wr_if.wr_en !== 4'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL mon_unexpected_write cyc=%0d en=%b addr=%h", cyc, wr_if.wr_en, wr_if.wr_addr);
                end else begin
                    w = exp_q.pop_front();
                    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{w.en[b]}};
                    if (w.full_cmp) m = 32'hFFFF_FFFF;
                    if (wr_if.wr_en !== w.en || wr_if.wr_addr !== w.addr || (wr_if.wr_data & m) !== (w.data & m))
                        begin errors++; $display("FAIL mon_write cyc=%0d got en=%b addr=%h data=%h required en=%b addr=%h data=%h mask=%h", cyc, wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, w.en, w.addr, w.data, m); end
                    if (cyc < w.acc_cyc + 2 || busy_prev)
                        begin errors++; $display("FAIL mon_write_timing cyc=%0d accepted=%0d busy_prev=%b required later write and busy 0", cyc, w.acc_cyc, busy_prev); end
                    if (w.last) pending--;
                end
            end else begin
                checks++;
                if (wr_if.wr_addr !== last_addr || wr_if.wr_data !== last_data)
                    begin errors++; $display("FAIL mon_hold cyc=%0d got addr=%h data=%h required addr=%h data=%h", cyc, wr_if.wr_addr, wr_if.wr_data, last_addr, last_data); end
            end
            checks++;
            if (req_ready !== (pending < DEPTH) || idle !== (pending == 0))
                begin errors++; $display("FAIL mon_ready_idle cyc=%0d got rdy=%b idle=%b required rdy=%b idle=%b", cyc, req_ready, idle, pending < DEPTH, pending == 0); end
        end
        last_addr = wr_if.wr_addr;
        last_data = wr_if.wr_data;
        rst_prev  = rst;
        busy_prev = mem_busy;
        acc_p     = req_valid && req_ready && !rst;
        a_p       = req_addr;
        d_p       = req_data;
        s_p       = req_size;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        @(negedge clk);
        checks++;
        if (wr_if.wr_en !== 4'b0 || wr_if.wr_addr !== 32'h0 || wr_if.wr_data !== 32'h0)
            begin errors++; $display("FAIL reset_outputs en=%b addr=%h data=%h required zeros", wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data); end
        checks++;
        if (req_ready !== 1'b1 || misalign !== 1'b0 || idle !== 1'b1)
            begin errors++; $display("FAIL reset_flags rdy=%b mis=%b idle=%b required 1/0/1", req_ready, misalign, idle); end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_single_sb;
        tick;
        drive(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00);
        tick;
        req_valid = 1'b0;
        tick;
        @(negedge clk);
        checks++;
        if (wr_if.wr_en !== 4'b1000 || wr_if.wr_addr !== 32'h0000_1000 || wr_if.wr_data !== 32'hA5A5_A5A5)
            begin errors++; $display("FAIL single_sb got en=%b addr=%h data=%h required 1000/00001000/a5a5a5a5", wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data); end
        repeat (3) tick;
    endtask

    task automatic test_back_to_back;
        tick;
        drive(1'b1, 32'h0000_2002, 32'h0000_1234, 2'b01);
        tick;
        drive(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 2'b10);
        tick;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_if.wr_en !== 4'b1100 || wr_if.wr_addr !== 32'h0000_2000 || wr_if.wr_data !== 32'h1234_1234)
            begin errors++; $display("FAIL b2b_first got en=%b addr=%h data=%h required 1100/00002000/12341234", wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data); end
        tick;
        @(negedge clk);
        checks++;
        if (wr_if.wr_en !== 4'b1111 || wr_if.wr_addr !== 32'h0000_2004 || wr_if.wr_data !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL b2b_second got en=%b addr=%h data=%h required 1111/00002004/deadbeef", wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data); end
        tick;
        @(negedge clk);
        checks++;
        if (wr_if.wr_en !== 4'b0000)
            begin errors++; $display("FAIL b2b_after got en=%b required 0000", wr_if.wr_en); end
        repeat (2) tick;
    endtask

    task automatic test_full;
        tick;
        mem_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h0000_3000 + 32'(4 * k), $urandom, 2'b10);
            tick;
        end
        drive(1'b1, 32'h0000_3010, 32'h5555_AAAA, 2'b10);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0)
            begin errors++; $display("FAIL full_ready_drop got=%b required=0", req_ready); end
        tick;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || wr_if.wr_en !== 4'b0)
            begin errors++; $display("FAIL full_busy_hold rdy=%b en=%b required 0/0000", req_ready, wr_if.wr_en); end
        tick;
        mem_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0)
            begin errors++; $display("FAIL full_pop_cycle_ready got=%b required=0", req_ready); end
        tick;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || wr_if.wr_addr !== 32'h0000_3000)
            begin errors++; $display("FAIL full_after_pop rdy=%b addr=%h required 1/00003000", req_ready, wr_if.wr_addr); end
        tick;
        req_valid = 1'b0;
        repeat (8) tick;
        @(negedge clk);
        checks++;
        if (wr_if.wr_addr !== 32'h0000_3010 || wr_if.wr_data !== 32'h5555_AAAA)
            begin errors++; $display("FAIL full_fifth_last got addr=%h data=%h required 00003010/5555aaaa", wr_if.wr_addr, wr_if.wr_data); end
    endtask

    task automatic test_misalign;
        logic [3:0] e1, e2;
        logic       m1;
        e1 = SPLIT_EN ? 4'b1110 : 4'b0000;
        e2 = SPLIT_EN ? 4'b0001 : 4'b0000;
        m1 = !SPLIT_EN;
        tick;
        drive(1'b1, 32'h0000_0101, 32'h1122_3344, 2'b10);
        tick;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (misalign !== m1)
            begin errors++; $display("FAIL misalign_sw_pulse got=%b required=%b", misalign, m1); end
        tick;
        @(negedge clk);
        checks++;
        if (wr_if.wr_en !== e1 || misalign !== 1'b0)
            begin errors++; $display("FAIL misalign_first got en=%b mis=%b required %b/0", wr_if.wr_en, misalign, e1); end
        tick;
        @(negedge clk);
        checks++;
        if (wr_if.wr_en !== e2)
            begin errors++; $display("FAIL misalign_second got en=%b required %b", wr_if.wr_en, e2); end
        tick;
        drive(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 2'b11);
        tick;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (misalign !== 1'b1)
            begin errors++; $display("FAIL illegal_size_pulse got=%b required=1", misalign); end
        tick;
        @(negedge clk);
        checks++;
        if (wr_if.wr_en !== 4'b0 || misalign !== 1'b0)
            begin errors++; $display("FAIL illegal_size_nowrite got en=%b mis=%b required 0000/0", wr_if.wr_en, misalign); end
        repeat (3) tick;
    endtask

    task automatic test_reset_mid;
        tick;
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0000_4000 + 32'(4 * k), $urandom, 2'b10);
            tick;
        end
        req_valid = 1'b0;
        mem_busy  = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        checks++;
        if (idle !== 1'b0)
            begin errors++; $display("FAIL reset_mid_queued idle=%b required 0", idle); end
        tick;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_if.wr_en !== 4'b0 || idle !== 1'b1)
            begin errors++; $display("FAIL reset_mid_after en=%b idle=%b required 0000/1", wr_if.wr_en, idle); end
        for (int i = 0; i < 5; i++) begin
            tick;
            @(negedge clk);
            checks++;
            if (wr_if.wr_en !== 4'b0)
                begin errors++; $display("FAIL reset_mid_nowrite i=%0d en=%b required 0000", i, wr_if.wr_en); end
        end
    endtask

    task automatic test_random;
        int         r;
        logic [1:0] sz;
        for (int i = 0; i < 400; i++) begin
            tick;
            mem_busy = ($urandom_range(0, 3) == 0);
            r  = int'($urandom_range(0, 7));
            sz = (r == 7) ? 2'b11 : 2'(r % 3);
            drive($urandom_range(0, 2) != 0, 32'h0000_5000 + 32'($urandom_range(0, 63)), $urandom, sz);
        end
        tick;
        req_valid = 1'b0;
        mem_busy  = 1'b0;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || pending != 0); i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || pending != 0 || idle !== 1'b1)
            begin errors++; $display("FAIL random_drain left=%0d pending=%0d idle=%b required 0/0/1", exp_q.size(), pending, idle); end
    endtask

    initial begin
        test_reset;
        test_single_sb;
        test_back_to_back;
        test_full;
        test_misalign;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
